// File: rtl/alu_op_sequencer.sv
// Issue-side sequencer for a fixed-latency pipelined 8-bit ALU: credit-gated issue,
// tag tracking, response FIFO. Optional operand cross-check enabled by ALU_SEQ_CHECK_EN.
module alu_op_sequencer #(
  parameter int ALU_LATENCY = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [1:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [1:0]       alu_opcode,
  input  logic [7:0]       alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [2:0]       inflight,
  output logic             mismatch
);

  localparam int STG   = ALU_LATENCY + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Reference ALU behaviour; add/sub wrap modulo 256.
  function automatic logic [7:0] alu_eval(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    logic [7:0] r;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    return r;
  endfunction

  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic [STG-1:0]   vld_p;
  logic [TAG_W-1:0] tag_p [STG];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [2:0]       inflight_q;
  logic [7:0]       credit_used;
  logic [7:0]       mem_data [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag  [FIFO_DEPTH];

  // Credits count both queued and in-flight results, so the ALU never outruns the FIFO.
  assign credit_used = 8'(fifo_count) + 8'(inflight_q);
  assign cmd_ready   = credit_used < 8'(FIFO_DEPTH);
  assign accept      = cmd_valid & cmd_ready;
  assign push        = vld_p[STG-1];
  assign full        = fifo_count == CNT_W'(FIFO_DEPTH);
  assign rsp_valid   = fifo_count != '0;
  assign pop         = rsp_valid & rsp_ready;
  assign rsp_data    = rsp_valid ? mem_data[rd_ptr] : '0;
  assign rsp_tag     = rsp_valid ? mem_tag[rd_ptr] : '0;
  assign inflight    = inflight_q;

  // Stage p0: ALU drive registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else if (accept) begin
      alu_a      <= cmd_a;
      alu_b      <= cmd_b;
      alu_opcode <= cmd_op;
    end
  end

  // Stages p0..pN: tracking valid/tag, aligned with the ALU pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p <= '0;
    else       vld_p <= {vld_p[STG-2:0], accept};
  end

  always_ff @(posedge clk) begin
    tag_p[0] <= cmd_tag;
    for (int i = 1; i < STG; i++) tag_p[i] <= tag_p[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) inflight_q <= '0;
    else if (accept && !push) inflight_q <= inflight_q + 3'd1;
    else if (!accept && push) inflight_q <= inflight_q - 3'd1;
  end

  // Capture stage: response FIFO
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= alu_result;
      mem_tag[wr_ptr]  <= tag_p[STG-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (!push && pop) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));

`ifdef ALU_SEQ_CHECK_EN
  logic [7:0] a_p  [STG];
  logic [7:0] b_p  [STG];
  logic [1:0] op_p [STG];
  logic       mismatch_q;

  always_ff @(posedge clk) begin
    a_p[0]  <= cmd_a;
    b_p[0]  <= cmd_b;
    op_p[0] <= cmd_op;
    for (int i = 1; i < STG; i++) begin
      a_p[i]  <= a_p[i-1];
      b_p[i]  <= b_p[i-1];
      op_p[i] <= op_p[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mismatch_q <= 1'b0;
    else if (push && (alu_result != alu_eval(a_p[STG-1], b_p[STG-1], op_p[STG-1])))
      mismatch_q <= 1'b1;
  end

  assign mismatch = mismatch_q;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a 3-stage ALU model and a response scoreboard.
module tb_alu_op_sequencer;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_a;
  logic [7:0]       cmd_b;
  logic [1:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic [1:0]       alu_opcode;
  logic [7:0]       alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic [2:0]       inflight;
  logic             mismatch;

  logic       corrupt;
  logic [7:0] r1, r2, r3;
  int         vectors = 0;
  int         miscompares = 0;
  logic [TAG_W+7:0] sb [$];

`ifdef ALU_SEQ_CHECK_EN
  localparam logic MISMATCH_EXP = 1'b1;
`else
  localparam logic MISMATCH_EXP = 1'b0;
`endif

  alu_op_sequencer #(.ALU_LATENCY(3), .FIFO_DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .inflight(inflight), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] op);
    logic [8:0] s;
    case (op)
      2'd0:    s = {1'b0, a} + {1'b0, b};
      2'd1:    s = {1'b0, a} - {1'b0, b};
      2'd2:    s = {1'b0, a & b};
      default: s = {1'b0, a | b};
    endcase
    return s[7:0];
  endfunction

  // Three-register ALU: result for operands registered at E0 is visible after E0+3.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      r1 <= '0; r2 <= '0; r3 <= '0;
    end else begin
      r1 <= model(alu_a, alu_b, alu_opcode);
      r2 <= r1;
      r3 <= r2;
    end
  end
  assign alu_result = corrupt ? 8'h00 : r3;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic [TAG_W-1:0] tag, input bit zero_res);
    bit done = 1'b0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        sb.push_back({tag, zero_res ? 8'h00 : model(a, b, op)});
        done = 1'b1;
      end
      tick();
    end
    cmd_valid = 1'b0;
    vectors++;
    assert (done) else begin
      miscompares++;
      $error("FAIL issue_timeout: tag %0d not accepted, required accept within 40 cycles", tag);
    end
  endtask

  // Scoreboard: every handshaken response must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        assert (sb.size() != 0) else begin
          miscompares++;
          $error("FAIL rsp_unexpected: observed tag=%0d data=%h, required no response",
                 rsp_tag, rsp_data);
        end
      end else begin
        check("rsp_tag_data", 32'({rsp_tag, rsp_data}), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    int accepts;
    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    rsp_ready = 1'b0; corrupt = 1'b0;
    repeat (2) tick();
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_inflight", 32'(inflight), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_mismatch", 32'(mismatch), 0);
    reset = 1'b0;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 1);

    // Single add, latency and inflight profile
    issue(8'h12, 8'h34, 2'd0, 4'd1, 1'b0);
    check("t1_alu_a", 32'(alu_a), 32'h12);
    check("t1_alu_b", 32'(alu_b), 32'h34);
    check("t1_alu_op", 32'(alu_opcode), 0);
    check("t1_inflight_e0", 32'(inflight), 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("t1_inflight_mid", 32'(inflight), 1);
      check("t1_rsp_valid_early", 32'(rsp_valid), 0);
    end
    tick();
    check("t1_rsp_valid_e4", 32'(rsp_valid), 1);
    check("t1_inflight_e4", 32'(inflight), 0);
    rsp_ready = 1'b1;
    tick();
    check("t1_drained", 32'(rsp_valid), 0);

    // Back-to-back sub wrap, and, or
    issue(8'h10, 8'h20, 2'd1, 4'd2, 1'b0);
    issue(8'hF0, 8'h3C, 2'd2, 4'd3, 1'b0);
    issue(8'hF0, 8'h0F, 2'd3, 4'd4, 1'b0);
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    check("t2_first", 32'(rsp_valid), 1);
    tick(); check("t2_second", 32'(rsp_valid), 1);
    tick(); check("t2_third", 32'(rsp_valid), 1);
    tick(); check("t2_empty", 32'(rsp_valid), 0);

    // Backpressure: only FIFO_DEPTH commands get credit
    rsp_ready = 1'b0;
    accepts = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cmd_a = 8'(i * 37 + 3); cmd_b = 8'(i * 11 + 200); cmd_op = 2'(i); cmd_tag = TAG_W'(i + 5);
      @(negedge clk);
      if (cmd_ready) begin
        sb.push_back({cmd_tag, model(cmd_a, cmd_b, cmd_op)});
        accepts++;
      end
      tick();
    end
    cmd_valid = 1'b0;
    check("t3_accepts", 32'(accepts), 4);
    check("t3_inflight", 32'(inflight), 0);
    check("t3_full_ready", 32'(cmd_ready), 0);
    check("t3_rsp_valid", 32'(rsp_valid), 1);
    rsp_ready = 1'b1;
    #1;
    check("t3_ready_not_comb", 32'(cmd_ready), 0);
    tick();
    check("t3_ready_after_pop", 32'(cmd_ready), 1);
    repeat (3) tick();
    check("t3_drained", 32'(rsp_valid), 0);
    check("t3_sb_empty", 32'(sb.size()), 0);

    // Full FIFO with simultaneous push and pop
    rsp_ready = 1'b0;
    issue(8'h81, 8'h7F, 2'd0, 4'd6, 1'b0);
    issue(8'h00, 8'h01, 2'd1, 4'd7, 1'b0);
    issue(8'hAA, 8'h0F, 2'd2, 4'd8, 1'b0);
    issue(8'h50, 8'h05, 2'd3, 4'd9, 1'b0);
    repeat (3) tick();
    check("t4_inflight_pre", 32'(inflight), 1);
    check("t4_ready_pre", 32'(cmd_ready), 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("t4_inflight_post", 32'(inflight), 0);
    check("t4_ready_post", 32'(cmd_ready), 1);
    check("t4_rsp_valid_post", 32'(rsp_valid), 1);
    rsp_ready = 1'b1;
    repeat (3) tick();
    check("t4_drained", 32'(rsp_valid), 0);
    check("t4_sb_empty", 32'(sb.size()), 0);

    // Asynchronous reset with results queued and in flight
    rsp_ready = 1'b0;
    issue(8'h11, 8'h22, 2'd0, 4'd1, 1'b0);
    issue(8'h33, 8'h44, 2'd0, 4'd2, 1'b0);
    repeat (4) tick();
    issue(8'h55, 8'h66, 2'd0, 4'd3, 1'b0);
    issue(8'h77, 8'h88, 2'd0, 4'd4, 1'b0);
    tick();
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("t5_rsp_valid", 32'(rsp_valid), 0);
    check("t5_inflight", 32'(inflight), 0);
    check("t5_alu_a", 32'(alu_a), 0);
    check("t5_alu_op", 32'(alu_opcode), 0);
    check("t5_rsp_tag", 32'(rsp_tag), 0);
    tick();
    reset = 1'b0;
    #1;
    check("t5_cmd_ready", 32'(cmd_ready), 1);
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t5_no_stale", 32'(rsp_valid), 0);
    end
    issue(8'h01, 8'h01, 2'd0, 4'd11, 1'b0);
    repeat (3) tick();
    check("t5_new_early", 32'(rsp_valid), 0);
    tick();
    check("t5_new_e4", 32'(rsp_valid), 1);
    tick();
    check("t5_mismatch_clean", 32'(mismatch), 0);
    check("t5_sb_empty", 32'(sb.size()), 0);

    // Corrupted ALU result for add 5+3
    corrupt = 1'b1;
    issue(8'h05, 8'h03, 2'd0, 4'd12, 1'b1);
    repeat (4) tick();
    corrupt = 1'b0;
    check("t6_mismatch", 32'(mismatch), 32'(MISMATCH_EXP));
    issue(8'h09, 8'h01, 2'd1, 4'd13, 1'b0);
    repeat (6) tick();
    check("t6_mismatch_sticky", 32'(mismatch), 32'(MISMATCH_EXP));
    check("t6_sb_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
